// File: rtl/mem_init.sv
// Power-up memory initialiser: copies COPY bytes from a paced synchronous ROM into
// main memory through a req/ack write port, then fills up to TOTAL bytes with FILL.
module mem_init #(
    parameter int             AW    = 19,
    parameter int             SW    = 16,
    parameter int             DW    = 8,
    parameter int             COPY  = 65536,
    parameter int             TOTAL = 524288,
    parameter logic [DW-1:0]  FILL  = '0
) (
    input  logic          i_clock,
    input  logic          i_reset,
    input  logic          i_ce,
    input  logic          i_ready,
    input  logic          i_restart,
    output logic [SW-1:0] o_srcA,
    input  logic [DW-1:0] i_srcQ,
    output logic          o_req,
    input  logic          i_ack,
    output logic [AW-1:0] o_a,
    output logic [DW-1:0] o_d,
    output logic          o_busy,
    output logic          o_done
);

    typedef enum logic [2:0] {
        S_IDLE, S_WAITRDY, S_READ, S_WRITE, S_NEXT, S_DONE
    } state_t;

    // One extra bit so COPY = 2^AW still compares correctly.
    localparam logic [AW:0]   COPY_X = (AW+1)'(COPY);
    localparam logic [AW-1:0] LAST   = AW'(TOTAL - 1);

    state_t          r_state, w_state_nxt;
    logic [AW-1:0]   r_n;
    logic            r_armed;
    logic [SW-1:0]   r_srcA;
    logic            r_req;
    logic [AW-1:0]   r_a;
    logic [DW-1:0]   r_d;
    logic            r_busy;
    logic            r_done;
    logic [AW-1:0]   w_n_inc;
    logic            w_inc_copy;
    logic            w_last;

    always_comb begin
        w_state_nxt = r_state;
        w_n_inc     = r_n + 1'b1;
        w_inc_copy  = ({1'b0, w_n_inc} < COPY_X);
        w_last      = (r_n == LAST);
        case (r_state)
            S_IDLE:    w_state_nxt = S_WAITRDY;
            S_WAITRDY: if (i_ready) w_state_nxt = S_READ;
            S_READ:    if (i_ce && r_armed) w_state_nxt = S_WRITE;
            S_WRITE:   if (i_ack && r_req) w_state_nxt = S_NEXT;
            S_NEXT: begin
                if (w_last)          w_state_nxt = S_DONE;
                else if (w_inc_copy) w_state_nxt = S_READ;
                else                 w_state_nxt = S_WRITE;
            end
            S_DONE:    if (i_restart) w_state_nxt = S_WAITRDY;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_n     <= '0;
            r_armed <= 1'b0;
            r_srcA  <= '0;
            r_req   <= 1'b0;
            r_a     <= '0;
            r_d     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: r_busy <= 1'b1;
                S_WAITRDY: begin
                    r_n     <= '0;
                    r_armed <= 1'b0;
                    if (i_ready) r_srcA <= '0;
                end
                S_READ: begin
                    // First ce presents the address to the ROM, second ce captures its data.
                    if (i_ce) begin
                        if (!r_armed) begin
                            r_armed <= 1'b1;
                        end else begin
                            r_d   <= i_srcQ;
                            r_a   <= r_n;
                            r_req <= 1'b1;
                        end
                    end
                end
                S_WRITE: if (i_ack && r_req) r_req <= 1'b0;
                S_NEXT: begin
                    if (w_last) begin
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                    end else begin
                        r_n     <= w_n_inc;
                        r_armed <= 1'b0;
                        if (w_inc_copy) begin
                            r_srcA <= SW'(w_n_inc);
                        end else begin
                            r_a   <= w_n_inc;
                            r_d   <= FILL;
                            r_req <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (i_restart) begin
                        r_done <= 1'b0;
                        r_busy <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_srcA = r_srcA;
    assign o_req  = r_req;
    assign o_a    = r_a;
    assign o_d    = r_d;
    assign o_busy = r_busy;
    assign o_done = r_done;

endmodule
